// File: rtl/data_bus_arbiter_pkg.sv
// Shared definitions for the MEM-stage data bus arbiter.
// Contents: bus owner encoding, bus width, default peripheral address nibble,
// and the address-space selection helper used by the decoder.
package data_bus_arbiter_pkg;

  localparam int BUS_W = 32;

  // Upper address nibble that selects the peripheral space by default.
  localparam logic [3:0] PER_NIB_DEF = 4'h4;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_t;

  // True when the top address nibble selects the peripheral space.
  function automatic logic per_space(input logic [3:0] addr_nib, input logic [3:0] sel_nib);
    return (addr_nib == sel_nib);
  endfunction

endpackage

// File: rtl/data_bus_arbiter_bus_addr_decode.sv
// Address decoder for the shared data bus.
// Routes the bus read/write strobes to either DataMem or the Peripheral
// block, based on the top address nibble. Only one target ever sees a strobe.
// Ports:
//   addr_nib  in  4  bus address bits [31:28]
//   rd, wr    in  1  bus read / write strobes from the current owner
//   mem_rd/mem_wr out 1  DataMem strobes
//   per_rd/per_wr out 1  Peripheral strobes
//   per_sel   out 1  access targets peripheral space (drives the read mux)
module bus_addr_decode
  import data_bus_arbiter_pkg::*;
#(
  parameter logic [3:0] PER_NIB = PER_NIB_DEF
) (
  input  logic [3:0] addr_nib,
  input  logic       rd,
  input  logic       wr,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       per_rd,
  output logic       per_wr,
  output logic       per_sel
);

  // Steer strobes to exactly one target space.
  always_comb begin
    mem_rd  = 1'b0;
    mem_wr  = 1'b0;
    per_rd  = 1'b0;
    per_wr  = 1'b0;
    per_sel = per_space(addr_nib, PER_NIB);
    if (per_sel) begin
      per_rd = rd;
      per_wr = wr;
    end else begin
      mem_rd = rd;
      mem_wr = wr;
    end
  end

endmodule

// File: rtl/data_bus_arbiter.sv
// Data bus arbiter between the pipeline CPU MEM stage and a DMA master.
// A registered owner FSM picks who drives the shared DataMem/Peripheral bus.
// The CPU has priority, but a waiting DMA is force-granted after STARVE_MAX
// CPU cycles, and a DMA burst is cut after MAX_BURST beats while the CPU waits.
// While the DMA owns the bus, a CPU access is stalled and issues no strobes.
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   cpu_rd/cpu_wr/cpu_addr/cpu_wdata  CPU MEM-stage access
//   cpu_rdata, cpu_stall    read data to MEM/WB, pipeline freeze
//   dma_req/dma_wr/dma_addr/dma_wdata DMA beat request
//   dma_gnt, dma_rdata      beat completes when dma_req & dma_gnt, read data
//   mem_rd/mem_wr, per_rd/per_wr      target strobes
//   bus_addr, bus_wdata     shared address / write data
//   mem_rdata, per_rdata    combinational read data from the targets
module data_bus_arbiter
  import data_bus_arbiter_pkg::*;
#(
  parameter int         STARVE_MAX = 4,
  parameter int         MAX_BURST  = 8,
  parameter logic [3:0] PER_NIB    = PER_NIB_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cpu_rd,
  input  logic             cpu_wr,
  input  logic [BUS_W-1:0] cpu_addr,
  input  logic [BUS_W-1:0] cpu_wdata,
  output logic [BUS_W-1:0] cpu_rdata,
  output logic             cpu_stall,
  input  logic             dma_req,
  input  logic             dma_wr,
  input  logic [BUS_W-1:0] dma_addr,
  input  logic [BUS_W-1:0] dma_wdata,
  output logic             dma_gnt,
  output logic [BUS_W-1:0] dma_rdata,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             per_rd,
  output logic             per_wr,
  output logic [BUS_W-1:0] bus_addr,
  output logic [BUS_W-1:0] bus_wdata,
  input  logic [BUS_W-1:0] mem_rdata,
  input  logic [BUS_W-1:0] per_rdata
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

  owner_t           owner;
  logic [3:0]       starve_cnt;
  logic [3:0]       beat_cnt;
  logic             cpu_acc;
  logic             bus_rd;
  logic             bus_wr;
  logic             per_sel;
  logic [BUS_W-1:0] rd_mux;

  assign cpu_acc   = cpu_rd | cpu_wr;
  assign dma_gnt   = (owner == OWN_DMA) & dma_req;
  assign cpu_stall = (owner == OWN_DMA) & cpu_acc;

  // Bus source mux: the registered owner drives address, data and strobes.
  // A DMA owner without a request (release cycle) issues no strobes.
  always_comb begin
    bus_addr  = cpu_addr;
    bus_wdata = cpu_wdata;
    bus_rd    = cpu_rd;
    bus_wr    = cpu_wr;
    if (owner == OWN_DMA) begin
      bus_addr  = dma_addr;
      bus_wdata = dma_wdata;
      bus_rd    = dma_req & ~dma_wr;
      bus_wr    = dma_req & dma_wr;
    end else begin
      bus_addr  = cpu_addr;
      bus_wdata = cpu_wdata;
      bus_rd    = cpu_rd;
      bus_wr    = cpu_wr;
    end
  end

  bus_addr_decode #(
    .PER_NIB (PER_NIB)
  ) u_decode (
    .addr_nib (bus_addr[31:28]),
    .rd       (bus_rd),
    .wr       (bus_wr),
    .mem_rd   (mem_rd),
    .mem_wr   (mem_wr),
    .per_rd   (per_rd),
    .per_wr   (per_wr),
    .per_sel  (per_sel)
  );

  // Read data return: zero-latency mux to the owner, zero to the other side.
  always_comb begin
    rd_mux    = per_sel ? per_rdata : mem_rdata;
    cpu_rdata = {BUS_W{1'b0}};
    dma_rdata = {BUS_W{1'b0}};
    if (owner == OWN_CPU) begin
      cpu_rdata = rd_mux;
    end else begin
      dma_rdata = rd_mux;
    end
  end

  // Owner FSM with DMA starvation counter and burst beat counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner      <= OWN_CPU;
      starve_cnt <= 4'd0;
      beat_cnt   <= 4'd0;
    end else begin
      case (owner)
        OWN_CPU: begin
          beat_cnt <= 4'd0;
          if (dma_req) begin
            if (cpu_acc && (starve_cnt < STARVE_LIM)) begin
              starve_cnt <= starve_cnt + 4'd1;
            end else begin
              owner      <= OWN_DMA;
              starve_cnt <= 4'd0;
            end
          end else begin
            starve_cnt <= 4'd0;
          end
        end
        OWN_DMA: begin
          starve_cnt <= 4'd0;
          // A dropped request and a burst-limit hit both return to the CPU;
          // the request drop is checked first so there is one transition.
          if (!dma_req) begin
            owner    <= OWN_CPU;
            beat_cnt <= 4'd0;
          end else if (cpu_acc && (beat_cnt >= BURST_LAST)) begin
            owner    <= OWN_CPU;
            beat_cnt <= 4'd0;
          end else if (beat_cnt < BURST_LAST) begin
            beat_cnt <= beat_cnt + 4'd1;
          end else begin
            // CPU idle: the burst limit does not apply, count saturates.
            beat_cnt <= beat_cnt;
          end
        end
        default: begin
          owner      <= OWN_CPU;
          starve_cnt <= 4'd0;
          beat_cnt   <= 4'd0;
        end
      endcase
    end
  end

endmodule
